instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 113 +++++++++++
 tb/tb_instruction_encoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Encodes data-processing field bundles into 32-bit instruction words and
// queues them in a small FIFO with valid/ready handshakes on both sides.
module instruction_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter logic [3:0]  COND  = 4'b1110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sel,
    input  logic [3:0]  opcode,
    input  logic        s,
    input  logic [3:0]  ra,
    input  logic [3:0]  rc,
    input  logic [3:0]  rb,
    input  logic [1:0]  shift,
    input  logic [4:0]  shift_imm,
    input  logic [3:0]  rotate_imm,
    input  logic [7:0]  immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        s_forced,
    output logic [15:0] enc_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   enc_count_q, enc_count_d;
    logic          s_forced_q, s_forced_d;

    logic          push, pop, is_cmp;
    logic [31:0]   word;

    // Compare ops (TST/TEQ/CMP/CMN) always set flags and have no destination.
    always_comb begin
        is_cmp        = (opcode[3:2] == 2'b10);
        word          = '0;
        word[31:28]   = COND;
        word[27:25]   = sel ? 3'b000 : 3'b001;
        word[24:21]   = opcode;
        word[20]      = is_cmp | s;
        word[19:16]   = ra;
        word[15:12]   = is_cmp ? 4'b0000 : rc;
        if (sel) begin
            word[11:7] = shift_imm;
            word[6:5]  = shift;
            word[4]    = 1'b0;
            word[3:0]  = rb;
        end else begin
            word[11:8] = rotate_imm;
            word[7:0]  = immediate;
        end
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rptr_q] : 32'h0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign s_forced  = s_forced_q;
    assign enc_count = enc_count_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        enc_count_d = enc_count_q;
        s_forced_d  = push && is_cmp && !s;
        if (push) begin
            wptr_d      = wptr_q + AW'(1);
            enc_count_d = enc_count_q + 16'd1;
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            enc_count_q <= '0;
            s_forced_q  <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
            s_forced_q  <= s_forced_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= word;
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
// Randomised self-checking bench for instruction_encoder against a queue model.
module tb_instruction_encoder;

    localparam int unsigned DEPTH = 4;
    localparam logic [3:0]  COND  = 4'b1110;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sel = 1'b0;
    logic [3:0]  opcode = '0;
    logic        s = 1'b0;
    logic [3:0]  ra = '0, rc = '0, rb = '0, rotate_imm = '0;
    logic [1:0]  shift = '0;
    logic [4:0]  shift_imm = '0;
    logic [7:0]  immediate = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        s_forced;
    logic [15:0] enc_count;

    int          vectors = 0;
    int          miscompares = 0;

    logic [31:0] q[$];
    logic [15:0] m_enc = '0;
    logic        m_sforced = 1'b0;

    always #5 clk = ~clk;

    instruction_encoder #(.DEPTH(DEPTH), .COND(COND)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .opcode(opcode), .s(s), .ra(ra), .rc(rc), .rb(rb),
        .shift(shift), .shift_imm(shift_imm), .rotate_imm(rotate_imm),
        .immediate(immediate), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .s_forced(s_forced), .enc_count(enc_count)
    );

    // Word built from the field rules with plain shifts and adds.
    function automatic logic [31:0] ref_encode();
        bit cmp;
        logic [31:0] w;
        cmp = (int'(opcode) >= 8) && (int'(opcode) <= 11);
        w = 32'(COND) << 28;
        w = w + (sel ? 32'd0 : 32'd1) * (32'd1 << 25);
        w = w + (32'(opcode) << 21);
        w = w + ((cmp || s) ? (32'd1 << 20) : 32'd0);
        w = w + (32'(ra) << 16);
        w = w + (cmp ? 32'd0 : (32'(rc) << 12));
        if (sel) w = w + (32'(shift_imm) << 7) + (32'(shift) << 5) + 32'(rb);
        else     w = w + (32'(rotate_imm) << 8) + 32'(immediate);
        return w;
    endfunction

    task automatic rand_fields();
        sel        = 1'($urandom);
        opcode     = 4'($urandom);
        s          = 1'($urandom);
        ra         = 4'($urandom);
        rc         = 4'($urandom);
        rb         = 4'($urandom);
        shift      = 2'($urandom);
        shift_imm  = 5'($urandom);
        rotate_imm = 4'($urandom);
        immediate  = 8'($urandom);
    endtask

    // Advance one clock and update the model; sampling happens 1ns after the edge.
    task automatic step();
        bit push, pop, cmp;
        logic [31:0] w;
        push = in_valid && (q.size() < DEPTH);
        pop  = out_ready && (q.size() > 0);
        cmp  = (int'(opcode) >= 8) && (int'(opcode) <= 11);
        w    = ref_encode();
        @(posedge clk);
        #1;
        if (pop)  void'(q.pop_front());
        if (push) begin
            q.push_back(w);
            m_enc = m_enc + 16'd1;
        end
        m_sforced = push && cmp && !s;
    endtask

    function automatic logic [31:0] exp_data();
        return (q.size() > 0) ? q[0] : 32'h0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1 ||
            enc_count !== 16'h0 || s_forced !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: valid=%b data=%h ready=%b cnt=%h sf=%b, want 0 0 1 0 0",
                     out_valid, out_data, in_ready, enc_count, s_forced);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_fixed(input string name, input logic [31:0] golden, input logic exp_sf);
        in_valid = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || out_data !== golden || out_data !== exp_data()) begin
            miscompares++;
            $display("FAIL %s word: valid=%b data=%h, want 1 %h", name, out_valid, out_data, golden);
        end
        vectors++;
        if (s_forced !== exp_sf || s_forced !== m_sforced) begin
            miscompares++;
            $display("FAIL %s s_forced: got %b want %b", name, s_forced, exp_sf);
        end
        step();
        vectors++;
        if (s_forced !== 1'b0) begin
            miscompares++;
            $display("FAIL %s s_forced_pulse: got %b want 0", name, s_forced);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL %s drain: valid=%b data=%h, want 0 0", name, out_valid, out_data);
        end
    endtask

    task automatic test_register();
        sel = 1'b1; opcode = 4'b0100; s = 1'b0; ra = 4'd1; rc = 4'd2; rb = 4'd3;
        shift = 2'b00; shift_imm = 5'd5;
        run_fixed("register", 32'hE0812283, 1'b0);
    endtask

    task automatic test_immediate();
        sel = 1'b0; opcode = 4'b1101; s = 1'b0; ra = 4'd0; rc = 4'd4;
        rotate_imm = 4'hF; immediate = 8'hFF;
        run_fixed("immediate", 32'hE3A04FFF, 1'b0);
    endtask

    task automatic test_compare();
        sel = 1'b0; opcode = 4'b1010; s = 1'b0; ra = 4'd1; rc = 4'd7;
        rotate_imm = 4'h0; immediate = 8'h05;
        run_fixed("compare", 32'hE3510005, 1'b1);
    endtask

    task automatic test_full();
        logic [15:0] start;
        start = enc_count;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_fields();
            in_valid = 1'b1;
            step();
            vectors++;
            if (in_ready !== (i < 3) || enc_count !== m_enc) begin
                miscompares++;
                $display("FAIL full push%0d: ready=%b cnt=%h, want %b %h", i, in_ready, enc_count, (i < 3), m_enc);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (enc_count !== start + 16'd4) begin
            miscompares++;
            $display("FAIL full count: got %h want %h", enc_count, start + 16'd4);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== (q.size() > 0) || out_data !== exp_data()) begin
                miscompares++;
                $display("FAIL full drain%0d: valid=%b data=%h, want %h", i, out_valid, out_data, exp_data());
            end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        logic [15:0] start;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_fields();
            in_valid = 1'b1;
            step();
        end
        start = enc_count;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== exp_data() ||
                q.size() != 2) begin
                miscompares++;
                $display("FAIL concurrent%0d: valid=%b ready=%b data=%h, want 1 1 %h",
                         i, out_valid, in_ready, out_data, exp_data());
            end
        end
        vectors++;
        if (enc_count !== start + 16'd10) begin
            miscompares++;
            $display("FAIL concurrent count: got %h want %h", enc_count, start + 16'd10);
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_fields();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
            vectors++;
            if (out_valid !== (q.size() > 0) || out_data !== exp_data() ||
                in_ready !== (q.size() < DEPTH) || s_forced !== m_sforced || enc_count !== m_enc) begin
                miscompares++;
                $display("FAIL random%0d: v=%b d=%h r=%b sf=%b c=%h, want %b %h %b %b %h", i,
                         out_valid, out_data, in_ready, s_forced, enc_count,
                         (q.size() > 0), exp_data(), (q.size() < DEPTH), m_sforced, m_enc);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        while (q.size() > 0) begin
            out_ready = 1'b1;
            step();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_enc = '0;
        m_sforced = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || enc_count !== 16'h0 || in_ready !== 1'b1 || out_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid: valid=%b cnt=%h ready=%b data=%h, want 0 0 1 0",
                     out_valid, enc_count, in_ready, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_mid post%0d: valid=%b data=%h, want 0 0", i, out_valid, out_data);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_register();
        test_immediate();
        test_compare();
        test_full();
        test_concurrent();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
